// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder: format codes, field
// bit positions within the encoded word, and the control state enum.
package instr_enc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 8;

  // Instruction format selector codes
  localparam logic [1:0] FMT_REG    = 2'd0;
  localparam logic [1:0] FMT_IMM    = 2'd1;
  localparam logic [1:0] FMT_BRANCH = 2'd2;
  localparam logic [1:0] FMT_SHIFT  = 2'd3;

  // Field positions inside the 32-bit encoded word
  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 24;
  localparam int unsigned BOFF_MSB  = 23;
  localparam int unsigned BOFF_LSB  = 16;
  localparam int unsigned DEST_MSB  = 18;
  localparam int unsigned DEST_LSB  = 16;
  localparam int unsigned SRC1_MSB  = 10;
  localparam int unsigned SRC1_LSB  = 8;
  localparam int unsigned SRC2_MSB  = 2;
  localparam int unsigned SRC2_LSB  = 0;
  localparam int unsigned IMM_MSB   = 7;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned SHAMT_MSB = 2;
  localparam int unsigned SHAMT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WRITE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: small show-ahead FIFO buffering encoded words between the
// field-input side and the instruction-memory write side.
module enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset since the count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 32-bit words, buffers them
// in enc_fifo and writes them sequentially into instruction memory.
// Optional feature macro ENC_CHECK_EN adds a sticky o_error flag for
// SHIFT instructions whose shift amount does not fit in 3 bits.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [9:0]  i_base_addr,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [1:0]  i_fmt,
  input  logic [7:0]  i_opcode,
  input  logic [2:0]  i_dest,
  input  logic [2:0]  i_src1,
  input  logic [2:0]  i_src2,
  input  logic [7:0]  i_immediate,
  output logic        o_mem_write,
  output logic [9:0]  o_mem_address,
  output logic [31:0] o_mem_writedata,
  input  logic        i_mem_busywait,
  output logic [7:0]  o_word_count
`ifdef ENC_CHECK_EN
  ,
  output logic        o_error
`endif
);

  enc_state_e        r_state;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_word_count;

  logic [WORD_W-1:0] w_packed;
  logic [WORD_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Ready only when armed and a slot is free; a concurrent pop never frees it
  assign o_in_ready = (r_state != ST_IDLE) && !w_full && !i_reset;
  assign w_push     = i_in_valid && o_in_ready;
  assign w_pop      = (r_state == ST_READY) && !w_empty;

  // Field packing by format; unused bits stay zero
  always_comb begin
    w_packed = '0;
    w_packed[OPC_MSB:OPC_LSB] = i_opcode;
    case (i_fmt)
      FMT_REG: begin
        w_packed[DEST_MSB:DEST_LSB] = i_dest;
        w_packed[SRC1_MSB:SRC1_LSB] = i_src1;
        w_packed[SRC2_MSB:SRC2_LSB] = i_src2;
      end
      FMT_IMM: begin
        w_packed[DEST_MSB:DEST_LSB] = i_dest;
        w_packed[IMM_MSB:IMM_LSB]   = i_immediate;
      end
      FMT_BRANCH: begin
        w_packed[BOFF_MSB:BOFF_LSB] = i_immediate;
        w_packed[SRC1_MSB:SRC1_LSB] = i_src1;
        w_packed[SRC2_MSB:SRC2_LSB] = i_src2;
      end
      FMT_SHIFT: begin
        w_packed[DEST_MSB:DEST_LSB]   = i_dest;
        w_packed[SRC1_MSB:SRC1_LSB]   = i_src1;
        w_packed[SHAMT_MSB:SHAMT_LSB] = i_immediate[SHAMT_MSB:SHAMT_LSB];
      end
      default: w_packed = '0;
    endcase
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_packed),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Control FSM: arm on start, pop a word into the write register, hold it
  // until memory stops stalling, then advance address and word count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_READY;
            r_addr       <= {i_base_addr[9:2], 2'b00};
            r_word_count <= '0;
          end
        end
        ST_READY: begin
          if (!w_empty) begin
            r_state     <= ST_WRITE;
            r_mem_write <= 1'b1;
            r_wdata     <= w_head;
          end
        end
        ST_WRITE: begin
          if (!i_mem_busywait) begin
            r_state      <= ST_READY;
            r_mem_write  <= 1'b0;
            r_addr       <= r_addr + ADDR_W'(4);
            r_word_count <= r_word_count + CNT_W'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_write     = r_mem_write;
  assign o_mem_address   = r_addr;
  assign o_mem_writedata = r_wdata;
  assign o_word_count    = r_word_count;

`ifdef ENC_CHECK_EN
  logic r_error;

  // Sticky flag for accepted SHIFT words whose amount overflows 3 bits
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_error <= 1'b0;
    end else if (w_push && (i_fmt == FMT_SHIFT) && (|i_immediate[7:3])) begin
      r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4). Table-driven single-word
// vectors plus directed sequences for stalls, FIFO full, wrap and reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [9:0]  i_base_addr;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [1:0]  i_fmt;
  logic [7:0]  i_opcode;
  logic [2:0]  i_dest;
  logic [2:0]  i_src1;
  logic [2:0]  i_src2;
  logic [7:0]  i_immediate;
  logic        o_mem_write;
  logic [9:0]  o_mem_address;
  logic [31:0] o_mem_writedata;
  logic        i_mem_busywait;
  logic [7:0]  o_word_count;
`ifdef ENC_CHECK_EN
  logic        o_error;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [7:0]  op;
    logic [2:0]  d;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [7:0]  imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];

  instr_encoder #(.DEPTH(4)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_base_addr     (i_base_addr),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .i_fmt           (i_fmt),
    .i_opcode        (i_opcode),
    .i_dest          (i_dest),
    .i_src1          (i_src1),
    .i_src2          (i_src2),
    .i_immediate     (i_immediate),
    .o_mem_write     (o_mem_write),
    .o_mem_address   (o_mem_address),
    .o_mem_writedata (o_mem_writedata),
    .i_mem_busywait  (i_mem_busywait),
    .o_word_count    (o_word_count)
`ifdef ENC_CHECK_EN
    ,
    .o_error         (o_error)
`endif
  );

  always #5 clk = ~clk;

  // Record every completed memory write (edge where write is high and not stalled)
  always @(posedge clk) begin
    if (!i_reset && o_mem_write && !i_mem_busywait) begin
      log_addr.push_back(o_mem_address);
      log_data.push_back(o_mem_writedata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic do_start(input logic [9:0] base);
    i_start     = 1'b1;
    i_base_addr = base;
    step();
    i_start     = 1'b0;
  endtask

  task automatic set_fields(input vec_t v);
    i_fmt       = v.fmt;
    i_opcode    = v.op;
    i_dest      = v.d;
    i_src1      = v.s1;
    i_src2      = v.s2;
    i_immediate = v.imm;
  endtask

  // Present a field set and hold it until accepted (bounded)
  task automatic push(input vec_t v);
    int n;
    n = 0;
    set_fields(v);
    i_in_valid = 1'b1;
    while (!o_in_ready && n < 40) begin
      step();
      n++;
    end
    chk("push_ready", 32'(o_in_ready), 32'd1);
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int c;
    c = 0;
    while (log_addr.size() < n && c < 60) begin
      step();
      c++;
    end
    chk("log_count", 32'(log_addr.size()), 32'(n));
  endtask

  function automatic vec_t mk(input logic [1:0] f, input logic [7:0] op, input logic [2:0] d,
                              input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] imm,
                              input logic [31:0] exp);
    vec_t v;
    v.fmt = f; v.op = op; v.d = d; v.s1 = s1; v.s2 = s2; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t w;
    int   hc;
    logic [9:0] a;

    vecs[0] = mk(2'd0, 8'h02, 3'd3, 3'd1, 3'd2, 8'hFF, 32'h02030102);
    vecs[1] = mk(2'd1, 8'h00, 3'd4, 3'd7, 3'd7, 8'h2A, 32'h0004002A);
    vecs[2] = mk(2'd2, 8'h06, 3'd7, 3'd1, 3'd2, 8'hFE, 32'h06FE0102);
    vecs[3] = mk(2'd3, 8'h08, 3'd5, 3'd6, 3'd7, 8'hFB, 32'h08050603);
    vecs[4] = mk(2'd0, 8'hFF, 3'd7, 3'd7, 3'd7, 8'h00, 32'hFF070707);

    i_reset = 1'b1; i_start = 1'b0; i_base_addr = '0; i_in_valid = 1'b0;
    i_fmt = '0; i_opcode = '0; i_dest = '0; i_src1 = '0; i_src2 = '0;
    i_immediate = '0; i_mem_busywait = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ready", 32'(o_in_ready), 32'd0);
    chk("rst_write", 32'(o_mem_write), 32'd0);
    chk("rst_addr", 32'(o_mem_address), 32'd0);
    chk("rst_wdata", o_mem_writedata, 32'd0);
    chk("rst_count", 32'(o_word_count), 32'd0);
`ifdef ENC_CHECK_EN
    chk("rst_error", 32'(o_error), 32'd0);
`endif

    // Valid in IDLE is ignored
    set_fields(vecs[0]);
    i_in_valid = 1'b1;
    step(); step(); step();
    chk("idle_ready", 32'(o_in_ready), 32'd0);
    i_in_valid = 1'b0;
    step(); step();
    chk("idle_nowrite", 32'(log_addr.size()), 32'd0);

    // Table: base low bits are dropped; each word checked for latency/data/addr
    do_start(10'h013);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        do_start(10'h300);
      end
      push(vecs[i]);
      chk($sformatf("v%0d_lat0", i), 32'(o_mem_write), 32'd0);
      step();
      chk($sformatf("v%0d_lat1", i), 32'(o_mem_write), 32'd1);
      chk($sformatf("v%0d_data", i), o_mem_writedata, vecs[i].exp);
      chk($sformatf("v%0d_addr", i), 32'(o_mem_address), 32'(10'h010 + 10'(4 * i)));
      step();
      chk($sformatf("v%0d_done", i), 32'(o_mem_write), 32'd0);
      chk($sformatf("v%0d_cnt", i), 32'(o_word_count), 32'(i + 1));
      chk($sformatf("v%0d_next", i), 32'(o_mem_address), 32'(10'h010 + 10'(4 * (i + 1))));
    end

    // Back-to-back IMM then BRANCH from base 0
    do_reset();
    do_start(10'h000);
    push(vecs[1]);
    push(vecs[2]);
    wait_log(2);
    if (log_addr.size() >= 2) begin
      chk("b2b_a0", 32'(log_addr[0]), 32'h000);
      chk("b2b_d0", log_data[0], 32'h0004002A);
      chk("b2b_a1", 32'(log_addr[1]), 32'h004);
      chk("b2b_d1", log_data[1], 32'h06FE0102);
    end

    // Busywait stall: write held 4 cycles with stable data/address
    do_reset();
    do_start(10'h100);
    i_mem_busywait = 1'b1;
    push(mk(2'd3, 8'h08, 3'd5, 3'd6, 3'd0, 8'h03, 32'h08050603));
    step();
    hc = 0;
    if (o_mem_write) hc++;
    chk("bw_data0", o_mem_writedata, 32'h08050603);
    for (int j = 0; j < 3; j++) begin
      step();
      if (o_mem_write) hc++;
      chk("bw_data", o_mem_writedata, 32'h08050603);
      chk("bw_addr", 32'(o_mem_address), 32'h100);
    end
    i_mem_busywait = 1'b0;
    step();
    if (o_mem_write) hc++;
    chk("bw_cycles", 32'(hc), 32'd4);
    chk("bw_addr_inc", 32'(o_mem_address), 32'h104);
    chk("bw_cnt", 32'(o_word_count), 32'd1);
    chk("bw_log", 32'(log_addr.size()), 32'd1);

    // FIFO full with memory stalled: 5 accepts then ready drops
    do_reset();
    do_start(10'h200);
    i_mem_busywait = 1'b1;
    for (int j = 0; j < 5; j++) begin
      w = mk(2'd0, 8'(8'h10 + j), 3'(j), 3'd1, 3'd2, 8'h00, 32'h0);
      push(w);
    end
    chk("full_ready", 32'(o_in_ready), 32'd0);
    w = mk(2'd0, 8'h55, 3'd0, 3'd0, 3'd0, 8'h00, 32'h0);
    set_fields(w);
    i_in_valid = 1'b1;
    step(); step();
    chk("full_hold", 32'(o_in_ready), 32'd0);
    i_in_valid = 1'b0;
    i_mem_busywait = 1'b0;
    wait_log(5);
    if (log_data.size() >= 5) begin
      for (int j = 0; j < 5; j++) begin
        chk("full_order", log_data[j], {8'(8'h10 + j), 5'd0, 3'(j), 5'd0, 3'd1, 5'd0, 3'd2});
        chk("full_addr", 32'(log_addr[j]), 32'(10'h200 + 10'(4 * j)));
      end
    end
    step(); step();
    chk("full_extra", 32'(log_addr.size()), 32'd5);

    // Address wrap at top of memory
    do_reset();
    do_start(10'h3FC);
    push(vecs[0]);
    push(vecs[4]);
    wait_log(2);
    if (log_addr.size() >= 2) begin
      chk("wrap_a0", 32'(log_addr[0]), 32'h3FC);
      chk("wrap_a1", 32'(log_addr[1]), 32'h000);
    end
    step();
    chk("wrap_cnt", 32'(o_word_count), 32'd2);

    // Reset during a stalled write discards it and the buffered word
    do_reset();
    do_start(10'h040);
    i_mem_busywait = 1'b1;
    push(vecs[0]);
    push(vecs[1]);
    step();
    chk("abort_pre", 32'(o_mem_write), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("abort_write", 32'(o_mem_write), 32'd0);
    chk("abort_addr", 32'(o_mem_address), 32'd0);
    chk("abort_cnt", 32'(o_word_count), 32'd0);
    chk("abort_ready", 32'(o_in_ready), 32'd0);
    i_mem_busywait = 1'b0;
    do_start(10'h080);
    hc = 0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (o_mem_write) hc++;
    end
    chk("abort_flushed", 32'(hc), 32'd0);
    chk("abort_rdy_again", 32'(o_in_ready), 32'd1);
    a = o_mem_address;
    chk("abort_base", 32'(a), 32'h080);

`ifdef ENC_CHECK_EN
    // Oversized shift amount flags error, word still written truncated
    do_reset();
    do_start(10'h000);
    push(mk(2'd3, 8'h08, 3'd5, 3'd6, 3'd0, 8'h09, 32'h0));
    chk("err_set", 32'(o_error), 32'd1);
    step();
    chk("err_data", 32'(o_mem_writedata[2:0]), 32'd1);
    push(vecs[0]);
    step(); step();
    chk("err_sticky", 32'(o_error), 32'd1);
    do_reset();
    chk("err_clear", 32'(o_error), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the encoded-word FIFO depth (power of two, 2..16).
REQ-002 CLK  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 RESET  in  1  SHALL be synchronous, active-high reset.
REQ-004 START  in  1  SHALL load BASE_ADDR and arm the block.
REQ-005 BASE_ADDR  in  10  SHALL give the first instruction-memory byte address (bits[1:0] forced 0).
REQ-006 IN_VALID  in  1  SHALL qualify the field inputs below.
REQ-007 IN_READY  out  1  SHALL indicate a field set can be accepted this cycle.
REQ-008 FMT  in  2  SHALL select format: 0 REG, 1 IMM, 2 BRANCH, 3 SHIFT.
REQ-009 OPCODE  in  8; DEST  in  3; SRC1  in  3; SRC2  in  3; IMMEDIATE  in  8 (immediate/offset/shift amount) SHALL carry the instruction fields.
REQ-010 MEM_WRITE  out  1; MEM_ADDRESS  out  10; MEM_WRITEDATA  out  32 SHALL form the instruction-memory write port.
REQ-011 MEM_BUSYWAIT  in  1  SHALL stall the current memory write while high.
REQ-012 WORD_COUNT  out  8  SHALL count words written since START.
REQ-013 ERROR  out  1  SHALL exist only when ENC_CHECK_EN is defined.

Function
REQ-014 Packing SHALL be: OPCODE->[31:24]; REG: DEST->[18:16], SRC1->[10:8], SRC2->[2:0]; IMM: DEST->[18:16], IMMEDIATE->[7:0]; BRANCH: IMMEDIATE->[23:16], SRC1->[10:8], SRC2->[2:0]; SHIFT: DEST->[18:16], SRC1->[10:8], IMMEDIATE[2:0]->[2:0]; all other bits 0.
REQ-015 Accept SHALL occur on a rising edge with IN_VALID && IN_READY; the packed word is pushed into the FIFO that edge.
REQ-016 IN_READY SHALL be combinational: state != IDLE and FIFO not full; a same-cycle pop SHALL NOT free a slot for a push.
REQ-017 States SHALL be IDLE, READY, WRITE; IDLE->READY on START (ADDRESS<=BASE_ADDR, WORD_COUNT<=0); READY->WRITE when FIFO non-empty (head popped into MEM_WRITEDATA register); WRITE->READY when MEM_BUSYWAIT is low.
REQ-018 MEM_WRITE SHALL be high exactly while in WRITE; MEM_ADDRESS and MEM_WRITEDATA SHALL be stable throughout WRITE.
REQ-019 On WRITE->READY, MEM_ADDRESS SHALL advance by 4 (1020 wraps to 0) and WORD_COUNT by 1 (255 wraps to 0).
REQ-020 Latency: word accepted at edge k into an empty FIFO in READY SHALL assert MEM_WRITE after edge k+1; minimum 2 cycles per word.
REQ-021 START in READY or WRITE SHALL be ignored; IN_VALID in IDLE SHALL be ignored.
REQ-022 FIFO full SHALL hold IN_READY low; empty SHALL keep state READY.

Reset
REQ-023 RESET SHALL force state IDLE, FIFO empty, MEM_WRITE 0, MEM_ADDRESS 0, MEM_WRITEDATA 0, WORD_COUNT 0, ERROR 0, IN_READY 0.
REQ-024 RESET during WRITE SHALL abort the write the next cycle; buffered words SHALL be discarded.

Configuration
REQ-025 Macro ENC_CHECK_EN defined: ERROR SHALL set sticky (until RESET) on accept of SHIFT with IMMEDIATE[7:3] != 0; the word is still written with amount truncated.
REQ-026 Macro ENC_CHECK_EN undefined: no ERROR port, no check logic.

Structure
REQ-027 Package instr_enc_pkg SHALL hold FMT codes, field bit positions and the state enum.
REQ-028 FIFO SHALL be sub-module enc_fifo (DEPTH, 32-bit, push/pop/full/empty).

Verification
REQ-029 START BASE_ADDR=0x010; REG OPCODE=0x02 DEST=3 SRC1=1 SRC2=2 -> MEM_WRITEDATA=0x02030102 at MEM_ADDRESS 0x010, WORD_COUNT=1.
REQ-030 IMM OPCODE=0x00 DEST=4 IMMEDIATE=0x2A, then BRANCH OPCODE=0x06 IMMEDIATE=0xFE SRC1=1 SRC2=2 -> 0x0004002A @0x000, 0x06FE0102 @0x004.
REQ-031 MEM_BUSYWAIT high 3 cycles during SHIFT OPCODE=0x08 DEST=5 SRC1=6 IMM=3 -> MEM_WRITE held 4 cycles, data 0x08050603 stable, one address increment.
REQ-032 BUSYWAIT stuck high, push DEPTH+1 words -> IN_READY low after 5th accept (DEPTH=4); release -> all words written in order.
REQ-033 BASE_ADDR=0x3FC, two words -> addresses 0x3FC then 0x000.
REQ-034 ENC_CHECK_EN: SHIFT IMMEDIATE=0x09 -> ERROR=1 sticky, data[2:0]=1; RESET clears ERROR.
